apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_master_arb.sv | 169 ++++++++++++++++
 tb/tb_apb_master_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS-phase timeout: define APB_MASTER_ARB_TIMEOUT_EN to compile it in.
// Grants are combinational in IDLE so the winner sees gnt in the same cycle its
// request is latched; responses are registered and pulse one cycle after completion.

module apb_master_arb #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // requester 0
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_gnt,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    // requester 1
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_gnt,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    // APB master
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t state, state_nxt;
    logic   last_grant;   // also identifies the owner of the in-flight transfer
    logic   win;
    logic   grant;
    logic   done;
    logic   tmo_hit;
    logic   tmo_fire;

    logic [1:0]             rsp_vld;
    logic [1:0][DATA_W-1:0] rsp_rd;
    logic [1:0]             rsp_er;

    // Round-robin pick: on a tie, favour the requester not granted last
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) win = ~last_grant;
        else if (req1_valid)          win = 1'b1;
    end

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state, APB control and grant pulses; gnt is gated by reset so a
    // pending request during reset never shows a grant
    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        req0_gnt  = 1'b0;
        req1_gnt  = 1'b0;
        grant     = 1'b0;
        done      = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (presetn && (req0_valid || req1_valid)) begin
                    grant     = 1'b1;
                    req0_gnt  = ~win;
                    req1_gnt  = win;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Count consecutive wait-state ACCESS cycles; cleared whenever the slave is ready or we leave ACCESS
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                      tmo_cnt <= '0;
        else if (state == ACCESS && !pready) tmo_cnt <= tmo_cnt + TW'(1);
        else                               tmo_cnt <= '0;
    end

    // Fires on the TIMEOUT_CYCLES-th wait cycle (counter holds the count of earlier ones)
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Latch the winner's command on the grant; values persist through IDLE
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant <= 1'b1;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else if (grant) begin
            last_grant <= win;
            pwrite     <= win ? req1_write : req0_write;
            paddr      <= win ? req1_addr  : req0_addr;
            if (win) pwdata <= req1_write ? req1_wdata : '0;
            else     pwdata <= req0_write ? req0_wdata : '0;
        end
    end

    // One-cycle response pulse to the transfer owner; data/err are zero when not pulsing
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_vld <= '0;
            rsp_rd  <= '0;
            rsp_er  <= '0;
        end else begin
            rsp_vld <= '0;
            rsp_rd  <= '0;
            rsp_er  <= '0;
            if (done) begin
                rsp_vld[last_grant] <= 1'b1;
                rsp_rd[last_grant]  <= pwrite ? '0 : prdata;
                rsp_er[last_grant]  <= pslverr;
            end else if (tmo_fire) begin
                rsp_vld[last_grant] <= 1'b1;
                rsp_er[last_grant]  <= 1'b1;
            end
        end
    end

    assign rsp0_valid = rsp_vld[0];
    assign rsp0_rdata = rsp_rd[0];
    assign rsp0_err   = rsp_er[0];
    assign rsp1_valid = rsp_vld[1];
    assign rsp1_rdata = rsp_rd[1];
    assign rsp1_err   = rsp_er[1];

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb. Inputs change just after the falling edge;
// outputs are checked 1ns later, well away from the rising edge.
module tb_apb_master_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              pclk, presetn;
    logic              req0_valid, req0_write, req0_gnt, rsp0_valid, rsp0_err;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
    logic              req1_valid, req1_write, req1_gnt, rsp1_valid, rsp1_err;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              psel, penable, pwrite, pready, pslverr;

    int vecs = 0;
    int errs = 0;

    apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_gnt(req0_gnt), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_gnt(req1_gnt), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable),
        .pwrite(pwrite), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(negedge pclk);
    endtask

    initial begin
        presetn = 1'b0;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        prdata = '0; pready = 0; pslverr = 0;

        // ---- reset state, with a request pending that must not be granted
        nx; req0_valid = 1; #1;
        chk("rst_gnt0", req0_gnt, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        req0_valid = 0;
        nx; presetn = 1;

        // ---- single write from req0, zero wait states
        nx; req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'hA5A5_0001; pready = 1; #1;
        chk("w_gnt0", req0_gnt, 1);
        chk("w_gnt1", req1_gnt, 0);
        chk("w_idle_psel", psel, 0);
        nx; req0_valid = 0; #1;
        chk("w_setup_psel", psel, 1);
        chk("w_setup_pen", penable, 0);
        chk("w_paddr", paddr, 32'h10);
        chk("w_pwdata", pwdata, 32'hA5A5_0001);
        chk("w_pwrite", pwrite, 1);
        chk("w_setup_gnt0", req0_gnt, 0);
        nx; #1;
        chk("w_access_psel", psel, 1);
        chk("w_access_pen", penable, 1);
        nx; pready = 0; #1;
        chk("w_rsp0", rsp0_valid, 1);
        chk("w_rsp0_err", rsp0_err, 0);
        chk("w_rsp0_rdata", rsp0_rdata, 0);
        chk("w_rsp1", rsp1_valid, 0);
        chk("w_idle_psel2", psel, 0);
        chk("w_paddr_hold", paddr, 32'h10);
        nx; #1;
        chk("w_rsp0_once", rsp0_valid, 0);

        // ---- req1 read with 3 wait states; stray prdata/pslverr ignored
        nx; req1_valid = 1; req1_write = 0; req1_addr = 32'h20; req1_wdata = 32'hFFFF_FFFF; #1;
        chk("r_gnt1", req1_gnt, 1);
        chk("r_gnt0", req0_gnt, 0);
        nx; req1_valid = 0; pslverr = 1; prdata = 32'h1111_1111; #1;
        chk("r_setup_pen", penable, 0);
        chk("r_paddr", paddr, 32'h20);
        chk("r_pwrite", pwrite, 0);
        chk("r_pwdata_zero", pwdata, 0);
        for (int i = 0; i < 3; i++) begin
            nx; #1;
            chk("r_wait_pen", penable, 1);
            chk("r_wait_paddr", paddr, 32'h20);
        end
        nx; pready = 1; pslverr = 0; prdata = 32'hDEAD_BEEF; #1;
        chk("r_last_pen", penable, 1);
        nx; pready = 0; prdata = '0; pslverr = 1; #1;
        chk("r_rsp1", rsp1_valid, 1);
        chk("r_rsp1_rdata", rsp1_rdata, 32'hDEAD_BEEF);
        chk("r_rsp1_err", rsp1_err, 0);
        chk("r_rsp0", rsp0_valid, 0);
        chk("r_psel", psel, 0);
        pslverr = 0;

        // ---- both held from reset: grants alternate 0,1,0,1
        nx; presetn = 0;
        nx; presetn = 1;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h100;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h200;
        pready = 1; prdata = 32'h5555;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt0", req0_gnt, (i % 2) == 0);
            chk("rr_gnt1", req1_gnt, (i % 2) == 1);
            if (i > 0) chk("rr_prev_rsp", (i % 2) == 1 ? rsp0_valid : rsp1_valid, 1);
            nx; #1;
            chk("rr_paddr", paddr, (i % 2) == 0 ? 32'h100 : 32'h200);
            nx; #1;
            chk("rr_pen", penable, 1);
            nx;
            if (i == 3) begin req0_valid = 0; req1_valid = 0; end
            #1;
        end
        chk("rr_end_gnt0", req0_gnt, 0);
        chk("rr_end_gnt1", req1_gnt, 0);
        chk("rr_end_rsp1", rsp1_valid, 1);
        chk("rr_end_rdata", rsp1_rdata, 32'h5555);

        // ---- slave error on req0 read; req1 write unaffected
        nx; req0_valid = 1; req0_write = 0; req0_addr = 32'h30;
        req1_valid = 1; req1_write = 1; req1_addr = 32'h40; req1_wdata = 32'h77; #1;
        chk("e_gnt0", req0_gnt, 1);
        chk("e_gnt1", req1_gnt, 0);
        nx; req0_valid = 0;
        nx; pslverr = 1; prdata = 32'hBAD0_0BAD;
        nx; pslverr = 0; prdata = '0; #1;
        chk("e_rsp0", rsp0_valid, 1);
        chk("e_rsp0_err", rsp0_err, 1);
        chk("e_rsp0_rdata", rsp0_rdata, 32'hBAD0_0BAD);
        chk("e_gnt1_coinc", req1_gnt, 1);
        nx; req1_valid = 0; #1;
        chk("e_pwrite", pwrite, 1);
        chk("e_paddr", paddr, 32'h40);
        chk("e_pwdata", pwdata, 32'h77);
        nx;
        nx; #1;
        chk("e_rsp1", rsp1_valid, 1);
        chk("e_rsp1_err", rsp1_err, 0);
        chk("e_rsp1_rdata", rsp1_rdata, 0);

        // ---- reset in the middle of ACCESS
        pready = 0;
        nx; req0_valid = 1; req0_write = 1; req0_addr = 32'h50; req0_wdata = 32'h99; #1;
        chk("ar_gnt0", req0_gnt, 1);
        nx; req0_valid = 0;
        nx; #1;
        chk("ar_pen", penable, 1);
        #2 presetn = 0; #1;
        chk("ar_psel_async", psel, 0);
        chk("ar_pen_async", penable, 0);
        chk("ar_paddr", paddr, 0);
        chk("ar_pwdata", pwdata, 0);
        nx; pready = 1; #1;
        chk("ar_no_rsp0", rsp0_valid, 0);
        presetn = 1; req0_valid = 1; req1_valid = 1; req0_write = 0; req1_write = 0;
        #1;
        chk("ar_tie_gnt0", req0_gnt, 1);
        chk("ar_tie_gnt1", req1_gnt, 0);
        nx; req0_valid = 0; req1_valid = 0;
        nx;
        nx; #1;
        chk("ar_after_rsp0", rsp0_valid, 1);
        chk("ar_after_rsp1", rsp1_valid, 0);

        // ---- slave never ready
        pready = 0; prdata = 32'hCAFE_F00D;
        nx; req1_valid = 1; req1_write = 0; req1_addr = 32'h60; #1;
        chk("t_gnt1", req1_gnt, 1);
        nx; req1_valid = 0;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            nx; #1;
            chk("t_access", penable, 1);
        end
        nx; #1;
        chk("t_idle_psel", psel, 0);
        chk("t_rsp1", rsp1_valid, 1);
        chk("t_rsp1_err", rsp1_err, 1);
        chk("t_rsp1_rdata", rsp1_rdata, 0);
`else
        for (int i = 0; i < 40; i++) begin
            nx; #1;
            chk("nt_access", penable, 1);
            chk("nt_no_rsp", rsp1_valid, 0);
        end
        pready = 1;
        nx; pready = 0; #1;
        chk("nt_rsp1", rsp1_valid, 1);
        chk("nt_rdata", rsp1_rdata, 32'hCAFE_F00D);
        chk("nt_err", rsp1_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
